// File: rtl/branch_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : branch_ctrl_pkg
// Description : Shared types and constants for the branch resolution
//               controller: FSM state encoding, branch opcode encoding,
//               sequential PC step and the target-address helper.
// Revision    : 1.0 - initial release
// ============================================================================
package branch_ctrl_pkg;

  // Controller states; the encoding is only ever compared against itself.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_OPS = 2'd1,
    CMP      = 2'd2,
    RESP     = 2'd3
  } state_e;

  // Branch opcode as carried on req_op.
  typedef enum logic [1:0] {
    OP_BEQ    = 2'b00,
    OP_BNE    = 2'b01,
    OP_ALWAYS = 2'b10,
    OP_RSVD   = 2'b11
  } op_e;

  // Byte distance from a branch to its fall-through instruction.
  localparam logic [31:0] PC_STEP = 32'd4;

  // Next-PC for a resolved branch. The offset is a word offset, so it is
  // scaled by four; everything wraps modulo 2^32 with no overflow report.
  function automatic logic [31:0] branch_target(
    input logic [31:0] pc,
    input logic [31:0] offset,
    input logic        taken
  );
    logic [31:0] seq_pc;
    seq_pc = pc + PC_STEP;
    return taken ? (seq_pc + {offset[29:0], 2'b00}) : seq_pc;
  endfunction

endpackage
`default_nettype wire

// File: rtl/branch_resolve_ctrl_comparator.sv
`default_nettype none
// ============================================================================
// Module      : Comparator
// Description : Pure combinational equality comparator. SIG_EQ is high when
//               both operands carry the same value.
// Revision    : 1.0 - initial release
// ============================================================================
module Comparator #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             SIG_EQ
);

  // Bitwise equality of the two operands.
  assign SIG_EQ = (a_i == b_i);

endmodule
`default_nettype wire

// File: rtl/branch_resolve_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : branch_resolve_ctrl
// Description : Resolves one conditional/unconditional branch at a time.
//               Accepts a request in IDLE, waits for forwarded operands
//               (with a bounded timeout), compares them, and presents a
//               single-cycle response carrying taken/err/redirect_pc and a
//               front-end flush strobe. The front end is stalled whenever a
//               branch is in flight.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_resolve_ctrl
  import branch_ctrl_pkg::*;
#(
  parameter int MAX_WAIT = 7
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [31:0] req_pc,
  input  logic [31:0] req_offset,
  input  logic        ops_ready,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        abort,
  output logic        resp_valid,
  output logic        resp_taken,
  output logic        resp_err,
  output logic [31:0] redirect_pc,
  output logic        flush,
  output logic        stall
);

  // Counter is wide enough to hold MAX_WAIT itself, the value at which the
  // wait for operands gives up.
  localparam int               CNT_W   = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

  // --------------------------------------------------------------------------
  // State and latched request context
  // --------------------------------------------------------------------------
  state_e            state_q,  state_d;
  op_e               op_q,     op_d;
  logic [31:0]       pc_q,     pc_d;
  logic [31:0]       off_q,    off_d;
  logic [31:0]       rs_q,     rs_d;
  logic [31:0]       rt_q,     rt_d;
  logic [CNT_W-1:0]  cnt_q,    cnt_d;
  logic              taken_q,  taken_d;
  logic              err_q,    err_d;
  logic [31:0]       target_q, target_d;

  // Combinational helpers
  logic              cmp_eq;
  logic              cmp_taken;
  logic [CNT_W-1:0]  cnt_inc;

  // --------------------------------------------------------------------------
  // Equality comparator, fed only from the latched operand registers so the
  // compare never sees operands that change while the branch is in CMP.
  // --------------------------------------------------------------------------
  Comparator #(
    .WIDTH (32)
  ) u_comparator (
    .a_i    (rs_q),
    .b_i    (rt_q),
    .SIG_EQ (cmp_eq)
  );

  assign cnt_inc = cnt_q + 1'b1;

  // Branch direction from the latched opcode and the comparator result.
  always_comb begin
    cmp_taken = 1'b1;
    case (op_q)
      OP_BEQ:  cmp_taken = cmp_eq;
      OP_BNE:  cmp_taken = ~cmp_eq;
      default: cmp_taken = 1'b1;
    endcase
  end

  // --------------------------------------------------------------------------
  // Next-state and datapath update. Abort outranks both operand arrival and
  // the timeout while a branch is waiting or comparing; once in RESP the
  // response is committed and abort is no longer looked at.
  // --------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    pc_d     = pc_q;
    off_d    = off_q;
    rs_d     = rs_q;
    rt_d     = rt_q;
    cnt_d    = cnt_q;
    taken_d  = taken_q;
    err_d    = err_q;
    target_d = target_q;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          op_d     = op_e'(req_op);
          pc_d     = req_pc;
          off_d    = req_offset;
          cnt_d    = '0;
          taken_d  = 1'b0;
          err_d    = 1'b0;
          target_d = '0;
          case (op_e'(req_op))
            OP_BEQ, OP_BNE: state_d = WAIT_OPS;
            OP_ALWAYS:      state_d = CMP;
            default: begin
              // Reserved opcode: report an error straight away, falling
              // through to the sequential instruction.
              err_d    = 1'b1;
              target_d = req_pc + PC_STEP;
              state_d  = RESP;
            end
          endcase
        end
      end

      WAIT_OPS: begin
        if (abort) begin
          state_d = IDLE;
        end else if (ops_ready) begin
          rs_d    = rs_val;
          rt_d    = rt_val;
          state_d = CMP;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == CNT_MAX) begin
            err_d    = 1'b1;
            target_d = pc_q + PC_STEP;
            state_d  = RESP;
          end
        end
      end

      CMP: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          taken_d  = cmp_taken;
          err_d    = 1'b0;
          target_d = branch_target(pc_q, off_q, cmp_taken);
          state_d  = RESP;
        end
      end

      RESP: begin
        // Response is visible for exactly this one cycle.
        taken_d  = 1'b0;
        err_d    = 1'b0;
        target_d = '0;
        state_d  = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // State register with synchronous active-low reset clearing all context.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      op_q     <= OP_BEQ;
      pc_q     <= '0;
      off_q    <= '0;
      rs_q     <= '0;
      rt_q     <= '0;
      cnt_q    <= '0;
      taken_q  <= 1'b0;
      err_q    <= 1'b0;
      target_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      pc_q     <= pc_d;
      off_q    <= off_d;
      rs_q     <= rs_d;
      rt_q     <= rt_d;
      cnt_q    <= cnt_d;
      taken_q  <= taken_d;
      err_q    <= err_d;
      target_q <= target_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs: every response field is forced low outside the RESP cycle, and
  // an error response never reports taken or requests a flush.
  // --------------------------------------------------------------------------
  assign req_ready   = (state_q == IDLE);
  assign stall       = (state_q != IDLE);
  assign resp_valid  = (state_q == RESP);
  assign resp_taken  = resp_valid & taken_q & ~err_q;
  assign resp_err    = resp_valid & err_q;
  assign redirect_pc = resp_valid ? target_q : 32'd0;
  assign flush       = resp_valid & taken_q & ~err_q;

endmodule
`default_nettype wire

// File: tb/tb_branch_resolve_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_resolve_ctrl
// Description : Self-checking bench for branch_resolve_ctrl. A transaction
//               model turns each directed branch into per-cycle expectations
//               (busy window, response cycle and response fields) using the
//               latency and result rules; a monitor compares every output on
//               every cycle, and literal expectations pin the model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_resolve_ctrl;

  localparam int MW    = 7;
  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [31:0] req_pc;
  logic [31:0] req_offset;
  logic        ops_ready;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        abort;
  logic        resp_valid;
  logic        resp_taken;
  logic        resp_err;
  logic [31:0] redirect_pc;
  logic        flush;
  logic        stall;

  always #5 clk = ~clk;

  branch_resolve_ctrl #(
    .MAX_WAIT (MW)
  ) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_pc      (req_pc),
    .req_offset  (req_offset),
    .ops_ready   (ops_ready),
    .rs_val      (rs_val),
    .rt_val      (rt_val),
    .abort       (abort),
    .resp_valid  (resp_valid),
    .resp_taken  (resp_taken),
    .resp_err    (resp_err),
    .redirect_pc (redirect_pc),
    .flush       (flush),
    .stall       (stall)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  // Per-cycle expectations (default: idle, no response).
  bit        exp_busy [DEPTH];
  bit        exp_resp [DEPTH];
  bit        exp_tk   [DEPTH];
  bit        exp_err  [DEPTH];
  bit [31:0] exp_pc   [DEPTH];

  // Last response seen by the monitor.
  int        resp_cnt = 0;
  int        last_cyc = 0;
  bit        last_tk;
  bit        last_err;
  bit        last_fl;
  bit [31:0] last_pc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compares all outputs every cycle, 2 time units after the edge.
  initial begin
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
      #2;
      if (cyc < DEPTH) begin
        chk("req_ready",   {31'd0, req_ready},  {31'd0, ~exp_busy[cyc]});
        chk("stall",       {31'd0, stall},      {31'd0, exp_busy[cyc]});
        chk("resp_valid",  {31'd0, resp_valid}, {31'd0, exp_resp[cyc]});
        chk("resp_taken",  {31'd0, resp_taken}, {31'd0, exp_resp[cyc] & exp_tk[cyc]});
        chk("resp_err",    {31'd0, resp_err},   {31'd0, exp_resp[cyc] & exp_err[cyc]});
        chk("redirect_pc", redirect_pc,         exp_resp[cyc] ? exp_pc[cyc] : 32'd0);
        chk("flush",       {31'd0, flush},
            {31'd0, exp_resp[cyc] & exp_tk[cyc] & ~exp_err[cyc]});
      end
      if (resp_valid === 1'b1) begin
        resp_cnt++;
        last_cyc = cyc;
        last_tk  = resp_taken;
        last_err = resp_err;
        last_fl  = flush;
        last_pc  = redirect_pc;
      end
    end
  end

  // Drives one branch starting in the current (idle) cycle and records what
  // the outputs must be. w = cycles of ops_ready low before it rises,
  // ab = cycle offset of abort (or reset when use_rst), -1 for none.
  task automatic run_txn(input logic [1:0] op, input bit [31:0] pc, input bit [31:0] off,
                         input bit [31:0] rs, input bit [31:0] rt, input int w, input int ab,
                         input bit use_rst, input bit hold_next, output int t0);
    int        t;
    int        resp_off;
    int        len;
    bit        killed;
    bit        err;
    bit        tk;
    bit [31:0] tgt;
    t = cyc;
    if (op == 2'b11)      resp_off = 1;
    else if (op == 2'b10) resp_off = 2;
    else if (w >= MW)     resp_off = 1 + MW;
    else                  resp_off = 3 + w;
    killed = (ab >= 1) && (ab < resp_off);
    len    = killed ? ab : resp_off;
    err    = (op == 2'b11) || ((op[1] == 1'b0) && (w >= MW));
    if (err)              tk = 1'b0;
    else if (op == 2'b10) tk = 1'b1;
    else if (op == 2'b00) tk = (rs == rt);
    else                  tk = (rs != rt);
    tgt = pc + 32'd4 + (tk ? off * 32'd4 : 32'd0);
    for (int k = 1; k <= len; k++) exp_busy[t + k] = 1'b1;
    if (!killed) begin
      exp_resp[t + resp_off] = 1'b1;
      exp_tk[t + resp_off]   = tk;
      exp_err[t + resp_off]  = err;
      exp_pc[t + resp_off]   = tgt;
    end
    req_valid  = 1'b1;
    req_op     = op;
    req_pc     = pc;
    req_offset = off;
    abort      = (ab == 0);
    ops_ready  = 1'b0;
    rs_val     = $urandom();
    rt_val     = $urandom();
    for (int k = 1; k <= len; k++) begin
      @(negedge clk);
      req_valid  = hold_next && (k == len);
      req_op     = req_valid ? 2'b10 : 2'($urandom());
      req_pc     = req_valid ? 32'h2000 : $urandom();
      req_offset = req_valid ? 32'h1 : $urandom();
      ops_ready  = (op[1] == 1'b0) && (w < MW) && (k == 1 + w);
      rs_val     = ops_ready ? rs : $urandom();
      rt_val     = ops_ready ? rt : $urandom();
      abort      = (k == ab) && !use_rst;
      rst_n      = !(use_rst && (k == ab));
    end
    @(negedge clk);
    req_valid = 1'b0;
    ops_ready = 1'b0;
    abort     = 1'b0;
    rst_n     = 1'b1;
    t0 = t;
  endtask

  int t0;
  int rc;

  initial begin
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_op     = 2'b00;
    req_pc     = 32'd0;
    req_offset = 32'd0;
    ops_ready  = 1'b0;
    rs_val     = 32'd0;
    rt_val     = 32'd0;
    abort      = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset req_ready",  {31'd0, req_ready},  32'd1);
    chk("reset stall",      {31'd0, stall},      32'd0);
    chk("reset resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("reset redirect",   redirect_pc,         32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // BEQ equal, operands one cycle after handshake.
    run_txn(2'b00, 32'h1000, 32'h4, 32'h12345678, 32'h12345678, 0, -1, 0, 0, t0);
    chk("beq latency", 32'(last_cyc - t0), 32'd3);
    chk("beq pc",      last_pc, 32'h1014);
    chk("beq taken",   {31'd0, last_tk}, 32'd1);
    chk("beq flush",   {31'd0, last_fl}, 32'd1);

    // BNE equal operands: not taken.
    run_txn(2'b01, 32'h1000, 32'h4, 32'd5, 32'd5, 0, -1, 0, 0, t0);
    chk("bne taken", {31'd0, last_tk}, 32'd0);
    chk("bne pc",    last_pc, 32'h1004);
    chk("bne flush", {31'd0, last_fl}, 32'd0);

    // BNE unequal, three extra wait cycles, negative offset.
    run_txn(2'b01, 32'h1000, 32'hFFFF_FFF0, 32'd5, 32'd6, 3, -1, 0, 0, t0);
    chk("bne wait latency", 32'(last_cyc - t0), 32'd6);
    chk("bne wait pc",      last_pc, 32'h0FC4);

    // Timeout after MAX_WAIT cycles with no operands.
    run_txn(2'b00, 32'h3000, 32'h10, 32'd1, 32'd1, MW, -1, 0, 0, t0);
    chk("timeout latency", 32'(last_cyc - t0), 32'd8);
    chk("timeout err",     {31'd0, last_err}, 32'd1);
    chk("timeout taken",   {31'd0, last_tk}, 32'd0);
    chk("timeout pc",      last_pc, 32'h3004);

    // One cycle short of timeout: normal resolution.
    run_txn(2'b00, 32'h4000, 32'h1, 32'd9, 32'd9, MW - 1, -1, 0, 0, t0);
    chk("near timeout latency", 32'(last_cyc - t0), 32'd9);
    chk("near timeout pc",      last_pc, 32'h4008);

    // ALWAYS with wrap-around.
    run_txn(2'b10, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 32'd0, 32'd0, 0, -1, 0, 0, t0);
    chk("always latency", 32'(last_cyc - t0), 32'd2);
    chk("always pc",      last_pc, 32'hFFFF_FFFC);
    chk("always flush",   {31'd0, last_fl}, 32'd1);

    // Reserved op, with a request already waiting during its RESP cycle.
    run_txn(2'b11, 32'h500, 32'h8, 32'd0, 32'd0, 0, -1, 0, 1, t0);
    chk("rsvd latency", 32'(last_cyc - t0), 32'd1);
    chk("rsvd err",     {31'd0, last_err}, 32'd1);
    chk("rsvd pc",      last_pc, 32'h504);
    run_txn(2'b10, 32'h2000, 32'h1, 32'd0, 32'd0, 0, -1, 0, 0, t0);
    chk("held req latency", 32'(last_cyc - t0), 32'd2);
    chk("held req pc",      last_pc, 32'h2008);

    // Abort together with ops_ready: no response.
    rc = resp_cnt;
    run_txn(2'b00, 32'h1000, 32'h4, 32'd7, 32'd7, 0, 1, 0, 0, t0);
    chk("abort no resp", 32'(resp_cnt - rc), 32'd0);

    // Abort in IDLE ignored; this request also shows acceptance after abort.
    run_txn(2'b01, 32'h6000, 32'h2, 32'd1, 32'd2, 1, 0, 0, 0, t0);
    chk("idle abort pc", last_pc, 32'h600C);

    // Abort during the operand wait, then abort in CMP.
    rc = resp_cnt;
    run_txn(2'b00, 32'h1000, 32'h4, 32'd1, 32'd1, MW, 4, 0, 0, t0);
    run_txn(2'b00, 32'h1000, 32'h4, 32'd1, 32'd1, 0, 2, 0, 0, t0);
    chk("wait/cmp abort no resp", 32'(resp_cnt - rc), 32'd0);

    // Abort in RESP does not cancel the response.
    run_txn(2'b10, 32'h7000, 32'h0, 32'd0, 32'd0, 0, 2, 0, 0, t0);
    chk("resp abort pc",    last_pc, 32'h7004);
    chk("resp abort flush", {31'd0, last_fl}, 32'd1);

    // Reset during CMP discards the branch.
    rc = resp_cnt;
    run_txn(2'b10, 32'h8000, 32'h4, 32'd0, 32'd0, 0, 1, 1, 0, t0);
    chk("reset cmp no resp", 32'(resp_cnt - rc), 32'd0);

    // Normal operation after reset: BEQ unequal.
    run_txn(2'b00, 32'h9000, 32'h40, 32'd3, 32'd4, 0, -1, 0, 0, t0);
    chk("post reset pc",    last_pc, 32'h9004);
    chk("post reset taken", {31'd0, last_tk}, 32'd0);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
